linear_layer_pe_start_sched: RTL and testbench

LINEAR_LAYER_PE_START_SCHED -- requirements
Module: linear_layer_pe_start_sched

---
 rtl/linear_layer_sched_pkg.sv | 15 +
 rtl/linear_layer_pe_start_sched_fifo.sv | 60 ++++++
 rtl/linear_layer_pe_start_sched.sv | 151 +++++++++++++++
 tb/tb_linear_layer_pe_start_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/linear_layer_sched_pkg.sv
// Shared types and default sizing for the linear-layer PE start scheduler.
package linear_layer_sched_pkg;

   localparam int unsigned DEF_NUM_PE     = 4;
   localparam int unsigned DEF_FIFO_DEPTH = 2;
   localparam int unsigned DEF_CNT_W      = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_t;

endpackage

// File: rtl/linear_layer_pe_start_sched_fifo.sv
// Per-PE start-token FIFO: shift-register store, head always at entry 0.
module start_token_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 16
) (
   input  logic         ap_clk,
   input  logic         ap_rst_n,
   input  logic         wr,
   input  logic [W-1:0] din,
   input  logic         rd,
   output logic [W-1:0] dout,
   output logic         empty_n,
   output logic         full_n
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem [DEPTH];
   logic [OCC_W-1:0] occ;
   logic [OCC_W-1:0] occ_nxt;
   logic [IDX_W-1:0] wr_idx;
   logic             do_rd;
   logic             do_wr;

   // Pops on an empty FIFO and pushes on a full one are dropped.
   always_comb begin
      do_rd   = rd & empty_n;
      do_wr   = wr & full_n;
      occ_nxt = occ + OCC_W'(do_wr) - OCC_W'(do_rd);
      wr_idx  = IDX_W'(occ - OCC_W'(do_rd));
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         occ     <= '0;
         empty_n <= 1'b0;
         full_n  <= 1'b1;
      end else begin
         occ     <= occ_nxt;
         empty_n <= (occ_nxt != '0);
         full_n  <= (occ_nxt != OCC_W'(DEPTH));
      end
   end

   // A same-cycle push lands after the shift, so the later assignment wins.
   always_ff @(posedge ap_clk) begin
      if (do_rd) begin
         for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            mem[i] <= mem[i+1];
         end
      end
      if (do_wr) begin
         mem[wr_idx] <= din;
      end
   end

   assign dout = mem[0];

endmodule

// File: rtl/linear_layer_pe_start_sched.sv
// Hands tile start tokens round-robin to per-PE FIFOs and tracks tile completion.
module linear_layer_pe_start_sched
   import linear_layer_sched_pkg::*;
#(
   parameter int unsigned NUM_PE     = DEF_NUM_PE,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int unsigned CNT_W      = DEF_CNT_W
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [CNT_W-1:0]        cfg_num_tiles,
   output logic [NUM_PE-1:0]       pe_start_empty_n,
   input  logic [NUM_PE-1:0]       pe_start_read,
   output logic [NUM_PE*CNT_W-1:0] pe_tile_idx,
   input  logic [NUM_PE-1:0]       pe_done,
   output logic                    busy,
   output logic                    job_done,
   output logic                    err_flag
);

   localparam int unsigned PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

   sched_state_t      state;
   sched_state_t      state_nxt;
   logic [CNT_W-1:0]  num_tiles;
   logic [CNT_W-1:0]  issue_cnt;
   logic [CNT_W-1:0]  done_cnt;
   logic [CNT_W-1:0]  done_nxt;
   logic [CNT_W-1:0]  done_add;
   logic [CNT_W-1:0]  outst [NUM_PE];
   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  rr_nxt;
   logic [PTR_W-1:0]  sel_idx;
   logic [PTR_W-1:0]  cand;
   logic              sel_found;
   logic              err_set;
   logic [NUM_PE-1:0] fifo_full_n;
   logic [NUM_PE-1:0] wr_vec;
   logic [NUM_PE-1:0] done_ok;

   // Round-robin pick of the first non-full FIFO starting at rr_ptr.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      rr_nxt    = rr_ptr;
      wr_vec    = '0;
      if (state == ST_ISSUE) begin
         for (int unsigned i = 0; i < NUM_PE; i++) begin
            cand = PTR_W'((32'(rr_ptr) + i) % NUM_PE);
            if (!sel_found && fifo_full_n[cand]) begin
               sel_found = 1'b1;
               sel_idx   = cand;
            end
         end
         if (sel_found) begin
            wr_vec[sel_idx] = 1'b1;
            rr_nxt = (32'(sel_idx) == NUM_PE - 1) ? '0 : sel_idx + PTR_W'(1);
         end
      end
   end

   // Done pulses only count against outstanding tiles of an active job.
   always_comb begin
      done_ok  = '0;
      err_set  = 1'b0;
      done_add = '0;
      for (int unsigned p = 0; p < NUM_PE; p++) begin
         if (pe_done[p]) begin
            if ((state == ST_ISSUE || state == ST_DRAIN) && outst[p] != '0) begin
               done_ok[p] = 1'b1;
            end else begin
               err_set = 1'b1;
            end
         end
      end
      for (int unsigned p = 0; p < NUM_PE; p++) begin
         done_add = done_add + CNT_W'(done_ok[p]);
      end
      done_nxt = done_cnt + done_add;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (cfg_valid) state_nxt = (cfg_num_tiles == '0) ? ST_DONE : ST_ISSUE;
         ST_ISSUE: if (sel_found && issue_cnt == num_tiles - CNT_W'(1)) state_nxt = ST_DRAIN;
         ST_DRAIN: if (done_nxt == num_tiles) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) state <= ST_IDLE;
      else           state <= state_nxt;
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         num_tiles <= '0;
         issue_cnt <= '0;
         done_cnt  <= '0;
         rr_ptr    <= '0;
         err_flag  <= 1'b0;
         for (int unsigned p = 0; p < NUM_PE; p++) outst[p] <= '0;
      end else begin
         err_flag <= err_flag | err_set;
         for (int unsigned p = 0; p < NUM_PE; p++) begin
            outst[p] <= outst[p] + CNT_W'(wr_vec[p]) - CNT_W'(done_ok[p]);
         end
         if (state == ST_IDLE) begin
            if (cfg_valid) begin
               num_tiles <= cfg_num_tiles;
               issue_cnt <= '0;
               done_cnt  <= '0;
               rr_ptr    <= '0;
            end
         end else begin
            done_cnt <= done_nxt;
            if (sel_found) begin
               issue_cnt <= issue_cnt + CNT_W'(1);
               rr_ptr    <= rr_nxt;
            end
         end
      end
   end

   assign cfg_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign job_done  = (state == ST_DONE);

   for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
      start_token_fifo #(
         .DEPTH (FIFO_DEPTH),
         .W     (CNT_W)
      ) u_fifo (
         .ap_clk   (ap_clk),
         .ap_rst_n (ap_rst_n),
         .wr       (wr_vec[p]),
         .din      (issue_cnt),
         .rd       (pe_start_read[p]),
         .dout     (pe_tile_idx[p*CNT_W +: CNT_W]),
         .empty_n  (pe_start_empty_n[p]),
         .full_n   (fifo_full_n[p])
      );
   end

endmodule

// File: tb/tb_linear_layer_pe_start_sched.sv
// Directed bench for the PE start scheduler with a simple per-PE consumer model.
module tb_linear_layer_pe_start_sched;

   localparam int unsigned NUM_PE = 4;
   localparam int unsigned DEPTH  = 2;
   localparam int unsigned CNT_W  = 16;

   logic                    ap_clk = 1'b0;
   logic                    ap_rst_n;
   logic                    cfg_valid;
   logic                    cfg_ready;
   logic [CNT_W-1:0]        cfg_num_tiles;
   logic [NUM_PE-1:0]       pe_start_empty_n;
   logic [NUM_PE-1:0]       pe_start_read;
   logic [NUM_PE*CNT_W-1:0] pe_tile_idx;
   logic [NUM_PE-1:0]       pe_done;
   logic                    busy;
   logic                    job_done;
   logic                    err_flag;

   int          n_cmp = 0;
   int          n_mis = 0;
   int          jd_cnt = 0;
   int          order_bad = 0;
   int          jd_mark;
   int          tile_pe [32];
   int          last_idx [NUM_PE];
   logic [3:0]  sh [NUM_PE];
   logic [NUM_PE-1:0] pe_auto;

   always #5 ap_clk = ~ap_clk;

   linear_layer_pe_start_sched #(
      .NUM_PE     (NUM_PE),
      .FIFO_DEPTH (DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .ap_clk           (ap_clk),
      .ap_rst_n         (ap_rst_n),
      .cfg_valid        (cfg_valid),
      .cfg_ready        (cfg_ready),
      .cfg_num_tiles    (cfg_num_tiles),
      .pe_start_empty_n (pe_start_empty_n),
      .pe_start_read    (pe_start_read),
      .pe_tile_idx      (pe_tile_idx),
      .pe_done          (pe_done),
      .busy             (busy),
      .job_done         (job_done),
      .err_flag         (err_flag)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock; auto PEs pop any visible token and pulse done a few cycles later.
   task automatic tick();
      logic [CNT_W-1:0] t;
      logic             rd;
      @(posedge ap_clk);
      #1;
      if (job_done) jd_cnt++;
      for (int p = 0; p < int'(NUM_PE); p++) begin
         if (pe_auto[p]) begin
            rd = pe_start_empty_n[p];
            if (rd) begin
               t = pe_tile_idx[p*CNT_W +: CNT_W];
               if (t < 16'd32) tile_pe[t] = p;
               if (int'(t) <= last_idx[p]) order_bad++;
               last_idx[p] = int'(t);
            end
            pe_start_read[p] = rd;
            sh[p]            = {sh[p][2:0], rd};
            pe_done[p]       = sh[p][3];
         end
      end
   endtask

   task automatic set_auto(input logic [NUM_PE-1:0] v);
      pe_auto       = v;
      pe_start_read = '0;
      pe_done       = '0;
      for (int p = 0; p < int'(NUM_PE); p++) sh[p] = '0;
   endtask

   task automatic start_job(input int n);
      for (int i = 0; i < 32; i++) tile_pe[i] = -1;
      for (int p = 0; p < int'(NUM_PE); p++) last_idx[p] = -1;
      cfg_num_tiles = CNT_W'(n);
      cfg_valid     = 1'b1;
      tick();
      cfg_valid     = 1'b0;
   endtask

   task automatic wait_job(input string tag, input int max_cyc);
      int start;
      int n;
      start = jd_cnt;
      n     = 0;
      while (jd_cnt == start && n < max_cyc) begin
         tick();
         n++;
      end
      check_eq(tag, 32'(jd_cnt - start), 32'd1);
      repeat (3) tick();
      check_eq({tag, "_single"}, 32'(jd_cnt - start), 32'd1);
   endtask

   initial begin
      int exp_pe10 [10];
      exp_pe10 = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
      ap_rst_n      = 1'b0;
      cfg_valid     = 1'b0;
      cfg_num_tiles = '0;
      set_auto('0);
      tick();
      tick();
      check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_job_done", 32'(job_done), 32'd0);
      check_eq("rst_err", 32'(err_flag), 32'd0);
      check_eq("rst_empty_n", 32'(pe_start_empty_n), 32'd0);
      ap_rst_n = 1'b1;
      tick();

      // Eight tiles, all PEs consuming immediately.
      set_auto(4'hF);
      start_job(8);
      wait_job("t1_job_done", 200);
      for (int t = 0; t < 8; t++) check_eq($sformatf("t1_tile%0d_pe", t), 32'(tile_pe[t]), 32'(t % 4));
      check_eq("t1_order", 32'(order_bad), 32'd0);
      check_eq("t1_err", 32'(err_flag), 32'd0);
      check_eq("t1_busy", 32'(busy), 32'd0);

      // Zero-tile job goes straight to DONE.
      start_job(0);
      check_eq("t2_job_done", 32'(job_done), 32'd1);
      check_eq("t2_cfg_ready_low", 32'(cfg_ready), 32'd0);
      tick();
      check_eq("t2_job_done_off", 32'(job_done), 32'd0);
      check_eq("t2_cfg_ready", 32'(cfg_ready), 32'd1);
      check_eq("t2_no_tokens", 32'(pe_start_empty_n), 32'd0);

      // PE1 stalls: it gets two tokens, the others absorb the rest.
      set_auto(4'b1101);
      start_job(10);
      repeat (40) tick();
      check_eq("t3_stall_busy", 32'(busy), 32'd1);
      check_eq("t3_stall_no_done", 32'(jd_cnt), 32'd2);
      check_eq("t3_pe1_empty_n", 32'(pe_start_empty_n[1]), 32'd1);
      check_eq("t3_pe1_head", 32'(pe_tile_idx[CNT_W +: CNT_W]), 32'd1);
      set_auto(4'hF);
      wait_job("t3_job_done", 200);
      for (int t = 0; t < 10; t++) check_eq($sformatf("t3_tile%0d_pe", t), 32'(tile_pe[t]), 32'(exp_pe10[t]));
      check_eq("t3_order", 32'(order_bad), 32'd0);
      check_eq("t3_err", 32'(err_flag), 32'd0);

      // Manual PEs: write-to-visible latency, then four simultaneous done pulses.
      set_auto('0);
      start_job(4);
      check_eq("t4_not_yet_visible", 32'(pe_start_empty_n), 32'd0);
      tick();
      check_eq("t4_first_visible", 32'(pe_start_empty_n), 32'h1);
      check_eq("t4_pe0_head", 32'(pe_tile_idx[CNT_W-1:0]), 32'd0);
      repeat (4) tick();
      check_eq("t4_all_visible", 32'(pe_start_empty_n), 32'hF);
      check_eq("t4_pe3_head", 32'(pe_tile_idx[3*CNT_W +: CNT_W]), 32'd3);
      check_eq("t4_done_cnt0", 32'(dut.done_cnt), 32'd0);
      pe_start_read = 4'hF;
      tick();
      pe_start_read = '0;
      check_eq("t4_popped", 32'(pe_start_empty_n), 32'd0);
      pe_done = 4'hF;
      tick();
      pe_done = '0;
      check_eq("t4_done_cnt4", 32'(dut.done_cnt), 32'd4);
      check_eq("t4_job_done", 32'(job_done), 32'd1);
      check_eq("t4_err", 32'(err_flag), 32'd0);
      tick();
      check_eq("t4_idle", 32'(busy), 32'd0);

      // Done pulse on PE2 with nothing outstanding.
      start_job(4);
      pe_done = 4'b0100;
      tick();
      pe_done = '0;
      check_eq("t5_err_set", 32'(err_flag), 32'd1);
      check_eq("t5_done_cnt", 32'(dut.done_cnt), 32'd0);
      repeat (5) tick();
      pe_start_read = 4'hF;
      tick();
      pe_start_read = '0;
      pe_done = 4'hF;
      tick();
      pe_done = '0;
      check_eq("t5_job_done", 32'(job_done), 32'd1);
      repeat (3) tick();
      check_eq("t5_err_sticky", 32'(err_flag), 32'd1);

      // Reset mid-ISSUE with five tokens queued.
      ap_rst_n = 1'b0;
      tick();
      ap_rst_n = 1'b1;
      check_eq("t6_err_cleared", 32'(err_flag), 32'd0);
      start_job(10);
      repeat (5) tick();
      check_eq("t6_queued", 32'(pe_start_empty_n), 32'hF);
      check_eq("t6_busy", 32'(busy), 32'd1);
      jd_mark  = jd_cnt;
      ap_rst_n = 1'b0;
      tick();
      check_eq("t6_rst_empty_n", 32'(pe_start_empty_n), 32'd0);
      check_eq("t6_rst_busy", 32'(busy), 32'd0);
      check_eq("t6_rst_job_done", 32'(job_done), 32'd0);
      check_eq("t6_rst_cfg_ready", 32'(cfg_ready), 32'd1);
      ap_rst_n = 1'b1;
      repeat (3) tick();
      check_eq("t6_no_job_done", 32'(jd_cnt - jd_mark), 32'd0);
      set_auto(4'hF);
      start_job(8);
      wait_job("t6_rerun_done", 200);
      for (int t = 0; t < 8; t++) check_eq($sformatf("t6_tile%0d_pe", t), 32'(tile_pe[t]), 32'(t % 4));
      check_eq("t6_err", 32'(err_flag), 32'd0);

      // Done pulse while IDLE is a protocol error.
      set_auto('0);
      pe_done = 4'b0001;
      tick();
      pe_done = '0;
      check_eq("t7_idle_done_err", 32'(err_flag), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
